// File: rtl/seqgen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seqgen_pkg                                             |
// | Description : Shared constants, state encoding and LFSR step helper  |
// |               for the game sequence generator and its controller.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package seqgen_pkg;

  localparam int SEQ_DEPTH   = 32;
  localparam int SEQ_ADDR_W  = $clog2(SEQ_DEPTH);
  localparam int SEQ_DIGIT_W = 4;
  localparam int SEQ_LFSR_W  = 16;

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [SEQ_LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [SEQ_LFSR_W-1:0] SEQ_SEED  = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } seqState_t;

  // One Fibonacci shift: feedback is the XOR of the tapped bits.
  function automatic logic [SEQ_LFSR_W-1:0] lfsrStep(input logic [SEQ_LFSR_W-1:0] s);
    return {s[SEQ_LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_lfsr                                               |
// | Description : Free-running 16-bit Fibonacci LFSR. Steps every cycle  |
// |               out of reset so the sequence depends on player timing. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module seq_lfsr
  import seqgen_pkg::*;
#(
  parameter logic [SEQ_LFSR_W-1:0] SEED = SEQ_SEED
) (
  input  logic                  Clk,
  input  logic                  Rst,
  output logic [SEQ_LFSR_W-1:0] State
);

  logic [SEQ_LFSR_W-1:0] r_lfsr;

  // Shift register: reload the seed on reset, otherwise step every cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_lfsr <= SEED;
    else      r_lfsr <= lfsrStep(r_lfsr);
  end

  assign State = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/sequence_generator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sequence_generator                                     |
// | Description : Fills a DEPTH-entry digit memory with LFSR-derived     |
// |               digits bounded by the sampled difficulty, flags        |
// |               completion on FinGen and serves 2-cycle-latency reads. |
// |               Optional macro SEQGEN_REPEAT_FILTER_EN rejects a digit |
// |               equal to the previous one written in the same fill.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sequence_generator
  import seqgen_pkg::*;
#(
  parameter int                    DEPTH   = SEQ_DEPTH,
  parameter int                    ADDR_W  = $clog2(DEPTH),
  parameter int                    DIGIT_W = SEQ_DIGIT_W,
  parameter int                    LFSR_W  = SEQ_LFSR_W,
  parameter logic [SEQ_LFSR_W-1:0] SEED    = SEQ_SEED
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               GoGen,
  input  logic [DIGIT_W-1:0] Diff,
  input  logic [ADDR_W-1:0]  SeqAddr,
  output logic [DIGIT_W-1:0] RAMOutput,
  output logic               FinGen
);

  seqState_t          r_state, w_stateNext;
  logic [ADDR_W-1:0]  r_wrAddr, w_wrAddrNext;
  logic [DIGIT_W-1:0] r_diff, w_diffNext;
  logic               r_done, w_doneNext;
  logic               w_we;
  logic               w_accept;
  logic [DIGIT_W-1:0] w_dmax;
  logic [DIGIT_W-1:0] w_cand;
  logic [LFSR_W-1:0]  w_lfsr;
  logic               w_unusedLfsr;
  logic [ADDR_W-1:0]  r_addrQ;
  logic [DIGIT_W-1:0] r_mem [DEPTH];
`ifdef SEQGEN_REPEAT_FILTER_EN
  logic [DIGIT_W-1:0] r_lastDigit;
`endif

  seq_lfsr #(.SEED(SEED)) u_lfsr (
    .Clk   (Clk),
    .Rst   (Rst),
    .State (w_lfsr)
  );

  // Candidate digit is the low nibble of the current (pre-step) LFSR state.
  assign w_cand       = w_lfsr[DIGIT_W-1:0];
  assign w_unusedLfsr = ^w_lfsr[LFSR_W-1:DIGIT_W];

  // Difficulty 0 would otherwise allow only digit 0; treat it as 1.
  assign w_dmax = (r_diff == '0) ? DIGIT_W'(1) : r_diff;

  // Next-state logic: GoGen always (re)starts a fill from address 0.
  always_comb begin
    w_stateNext  = r_state;
    w_wrAddrNext = r_wrAddr;
    w_diffNext   = r_diff;
    w_doneNext   = r_done;
    w_we         = 1'b0;
    w_accept     = (w_cand <= w_dmax);
`ifdef SEQGEN_REPEAT_FILTER_EN
    if ((r_wrAddr != '0) && (w_cand == r_lastDigit)) w_accept = 1'b0;
`endif
    if (GoGen) begin
      w_stateNext  = FILL;
      w_wrAddrNext = '0;
      w_diffNext   = Diff;
      w_doneNext   = 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            w_we         = 1'b1;
            w_wrAddrNext = r_wrAddr + ADDR_W'(1);
            if (r_wrAddr == ADDR_W'(DEPTH - 1)) begin
              w_stateNext = DONE;
              w_doneNext  = 1'b1;
            end
          end
        end
        IDLE, DONE: w_stateNext = r_state;
        default:    w_stateNext = IDLE;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state  <= IDLE;
      r_wrAddr <= '0;
      r_diff   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_wrAddr <= w_wrAddrNext;
      r_diff   <= w_diffNext;
      r_done   <= w_doneNext;
    end
  end

`ifdef SEQGEN_REPEAT_FILTER_EN
  // Remember the most recent digit written so an immediate repeat is refused.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)      r_lastDigit <= '0;
    else if (w_we) r_lastDigit <= w_cand;
  end
`endif

  // Digit memory write port; contents deliberately survive reset.
  always_ff @(posedge Clk) begin
    if (w_we) r_mem[r_wrAddr] <= w_cand;
  end

  // Two-stage read: register the address, then register the data (old data on collision).
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_addrQ   <= '0;
      RAMOutput <= '0;
    end else begin
      r_addrQ   <= SeqAddr;
      RAMOutput <= r_mem[r_addrQ];
    end
  end

  // Mask done during GoGen so the controller never sees last round's flag.
  assign FinGen = r_done & ~GoGen;

endmodule
`default_nettype wire

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
Produces the random digit sequence the game controller replays and checks each round. It runs on the controller's GoGen pulse and fills a DEPTH-entry digit memory using an LFSR. Each digit is limited to the range set by the controller's Diff. It raises FinGen when the memory is full. It then serves the controller's SeqAddr reads on RAMOutput with a fixed 2-cycle latency.

Parameters:
DEPTH, 32, number of sequence entries; ADDR_W = clog2(DEPTH)
ADDR_W, 5, width of SeqAddr
DIGIT_W, 4, width of Diff and of each stored digit
LFSR_W, 16, LFSR width; taps fixed for 16 bits (x^16+x^14+x^13+x^11+1)
SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
Clk  in  1  system clock, all state on rising edge
Rst  in  1  asynchronous active-low reset
GoGen  in  1  one-cycle start pulse from controller; restarts generation
Diff  in  DIGIT_W  difficulty, sampled at the cycle GoGen=1
SeqAddr  in  ADDR_W  read address from controller
RAMOutput  out  DIGIT_W  registered read data
FinGen  out  1  sequence complete, level signal

Behaviour:
- Reset (Rst=0, async): state=IDLE, lfsr=SEED, wr_addr=0, done=0, RAMOutput=0, addr_q=0. Memory contents are not reset.
- LFSR (Fibonacci):
  - Free-runs every cycle when not in reset, in all states, so the seed depends on the player's timing.
  - Step: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Dmax = (Diff_q==0) ? 1 : Diff_q. Diff_q is captured on GoGen.
- States:
  - IDLE: wait. GoGen=1 -> FILL, wr_addr=0, Diff_q=Diff, done=0.
  - FILL, each cycle:
    - cand = lfsr[3:0] (pre-step value).
    - If cand <= Dmax: mem[wr_addr] <= cand and wr_addr++.
    - Else reject; nothing is written.
    - A write to wr_addr==DEPTH-1 -> DONE, done=1.
  - DONE: hold. GoGen=1 -> FILL, re-initialised as in IDLE.
- GoGen during FILL restarts the fill: wr_addr=0, Diff re-sampled, done stays 0.
- FinGen = done & ~GoGen (combinational mask). The controller samples FinGen in the cycle after it issues GoGen, and must never see the stale 1 from the previous round.
- Diff=15: every candidate is accepted, so FILL lasts exactly DEPTH cycles. If GoGen is sampled at edge E0, FinGen=1 after edge E32.
- Read path:
  - addr_q <= SeqAddr.
  - RAMOutput <= mem[addr_q].
  - Data is valid 2 edges after SeqAddr changes. This matches the controller's Fetch/Cyc1/Cyc2/Catch spacing, which samples at the 3rd edge.
- Reads during FILL are legal. They return whatever the memory holds at that address (previous or new digit); no X beyond memory init.
- Write and read to the same address in one cycle: read returns the old data (read-before-write).
- Termination: a maximal-length LFSR visits every low nibble, so FILL always finishes. The bench bounds FILL at 16*DEPTH cycles.

Optional Feature:
SEQGEN_REPEAT_FILTER_EN:
- Defined: a candidate equal to the digit last written in the current fill is also rejected; this applies to entries 1..DEPTH-1 only. Dmax>=1 always, so progress is guaranteed.
- Undefined: immediate repeats are allowed, and the timing for Diff=15 is exactly DEPTH cycles.

Decomposition:
- Package seqgen_pkg:
  - state enum {IDLE, FILL, DONE}
  - LFSR_TAPS constant
  - default SEED
  - DIGIT_W/ADDR_W constants shared with the controller
- Sub-module seq_lfsr (free-running LFSR with SEED parameter, exposes state). The memory stays inline as a registered-read array.

Test Plan:
- Reset: Rst=0 mid-FILL -> FinGen=0, RAMOutput=0 immediately. After release with no GoGen, FinGen stays 0 indefinitely.
- Diff=15, GoGen pulse -> FinGen rises exactly after edge 32 (macro off). Reading all 32 addresses gives values 0..15 matching a reference LFSR model started from the same cycle.
- Diff=0, then Diff=1 -> FinGen within 16*32 cycles. Every entry is in {0,1}; a golden model of the accept/reject sequence matches.
- Back-to-back rounds: FinGen=1, then a new GoGen -> FinGen=0 in the GoGen cycle and the next cycle. Completion follows a fresh fill; Diff=3 gives all entries <=3.
- GoGen re-pulsed at fill cycle 10 with Diff changed 9->2 -> fill restarts at addr 0. Final contents are all <=2 and FinGen appears only once.
- Read latency: SeqAddr=7 at edge A -> RAMOutput=mem[7] after edge A+2 and not before. With SEQGEN_REPEAT_FILTER_EN, Diff=1 -> entries alternate 0/1 with no adjacent repeats.
